// File: rtl/mod_instr_fetch.sv
// Instruction fetch stage: one-entry buffer in front of a wait-stated req/ack memory.
// Optional IFETCH_STALL_CNT_EN adds a saturating stall_count output.
module mod_instr_fetch #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NOP_WORD       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        hold,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic        fetch_fault
`ifdef IFETCH_STALL_CNT_EN
    ,
    output logic [31:0] stall_count
`endif
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, FAULT} state_t;

    state_t        state, state_nxt;
    logic          rg_valid;
    logic [31:0]   rg_tag;
    logic [31:0]   rg_instr;
    logic [CW-1:0] tmo_cnt;
    logic          hit;
    logic          tmo_hit;

    assign hit     = (state == IDLE) && rg_valid && (rg_tag == pc);
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!hit) state_nxt = (pc[1:0] != 2'b00) ? FAULT : WAIT;
            end
            WAIT: begin
                // ack takes priority over an expiring timeout in the same cycle
                if (imem_ack)     state_nxt = imem_err ? FAULT : IDLE;
                else if (tmo_hit) state_nxt = FAULT;
            end
            FAULT:   state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        hold        = !hit;
        instruction = hit ? rg_instr : NOP_WORD;
        fetch_fault = (state == FAULT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rg_valid  <= 1'b0;
            rg_tag    <= '0;
            rg_instr  <= '0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            tmo_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!hit && pc[1:0] == 2'b00) begin
                        imem_addr <= pc;
                        imem_req  <= 1'b1;
                        tmo_cnt   <= '0;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        if (imem_err) begin
                            rg_valid <= 1'b0;
                        end else begin
                            rg_valid <= 1'b1;
                            rg_tag   <= imem_addr;
                            rg_instr <= imem_rdata;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                        if (tmo_hit) imem_req <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef IFETCH_STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          stall_count <= '0;
        else if (hold && stall_count != '1) stall_count <= stall_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mod_instr_fetch.sv
// Bench for mod_instr_fetch: directed timing checks, then a randomized program run
// scored against a word/stall-latency model. Build with IFETCH_STALL_CNT_EN for stall_count checks.
module tb_mod_instr_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = '0;
    logic [31:0] instruction;
    logic        hold;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_err = 1'b0;
    logic        fetch_fault;
`ifdef IFETCH_STALL_CNT_EN
    logic [31:0] stall_count;
`endif

    always #5 clk = ~clk;

    mod_instr_fetch #(.TIMEOUT_CYCLES(8), .NOP_WORD(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .pc(pc),
        .instruction(instruction), .hold(hold),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_err(imem_err),
        .fetch_fault(fetch_fault)
`ifdef IFETCH_STALL_CNT_EN
        , .stall_count(stall_count)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    int rsp_wait = 0;
    bit rsp_err  = 1'b0;
    bit rsp_mute = 1'b0;
    bit rsp_spur = 1'b0;

    typedef struct {
        logic [31:0] word;
        int          holds;
    } exp_t;
    exp_t sbq[$];
    bit   mon_en = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2002_0005;
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] pick_pc();
        return 32'h0000_1000 + ($urandom_range(0, 7) << 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Memory: acks after rsp_wait wait cycles; optionally garbage acks while no request is pending
    initial begin : responder
        bit busy;
        int cnt;
        busy = 1'b0;
        cnt  = 0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (!busy) begin busy = 1'b1; cnt = 0; end
                if (!rsp_mute && cnt == rsp_wait) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    imem_err   = rsp_err;
                    busy       = 1'b0;
                end else begin
                    imem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                busy       = 1'b0;
                imem_ack   = rsp_spur && ($urandom_range(0, 3) == 0);
                imem_rdata = $urandom;
                imem_err   = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin : monitor
        int   hc;
        exp_t e;
        hc = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) hc = 0;
            else if (hold) hc++;
            else begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output actual=%h required=none", instruction);
                end else begin
                    e = sbq.pop_front();
                    chk("rand_word", instruction, e.word);
                    chk("rand_hold_cycles", hc, e.holds);
                end
                hc = 0;
            end
        end
    end

    // Processor model: after every hit cycle the PC moves (or repeats); a new address costs
    // one miss cycle plus wait+1 request cycles of hold, a repeat costs none.
    task automatic run_random(input int n);
        int          w, i, guard;
        logic [31:0] last;
        reset = 1'b1; mon_en = 1'b0;
        rsp_mute = 1'b0; rsp_err = 1'b0; rsp_spur = 1'b1;
        sbq.delete();
        @(posedge clk); #1;
        pc = pick_pc();
        w  = $urandom_range(0, 5);
        rsp_wait = w;
        sbq.push_back('{mem_word(pc), w + 2});
        last = pc;
        reset = 1'b0; mon_en = 1'b1;
        i = 1; guard = 0;
        while (i < n && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (!hold) begin
                @(posedge clk); #1;
                if ($urandom_range(0, 3) != 0) pc = pick_pc();
                w = $urandom_range(0, 5);
                rsp_wait = w;
                sbq.push_back('{mem_word(pc), (pc == last) ? 0 : w + 2});
                last = pc;
                i++;
            end
        end
        while (sbq.size() != 0 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        chk("rand_completed", 32'(guard < 5000), 32'd1);
        @(posedge clk); #1;
        mon_en = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : main
        int          rq, g, bad;
        logic [31:0] sc0;
        sc0 = '0;

        // reset state
        reset = 1'b1; pc = 32'h0; rsp_wait = 0;
        repeat (3) @(negedge clk);
        chk("rst_hold", hold, 1'b1);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_fault", fetch_fault, 1'b0);
`ifdef IFETCH_STALL_CNT_EN
        chk("rst_stall", stall_count, 32'h0);
`endif

        // first fill, zero-wait memory
        reset = 1'b0;
        @(negedge clk);
        chk("fill0_req", imem_req, 1'b1);
        chk("fill0_addr", imem_addr, 32'h0);
        chk("fill0_hold", hold, 1'b1);
        @(negedge clk);
        chk("fill0_hold_lo", hold, 1'b0);
        chk("fill0_instr", instruction, 32'h2002_0005);

        // four wait states at 0x40
`ifdef IFETCH_STALL_CNT_EN
        sc0 = stall_count;
`endif
        pc = 32'h40; rsp_wait = 4;
        #1 chk("pc40_hold_rise", hold, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("pc40_req", imem_req, 1'b1);
            chk("pc40_addr", imem_addr, 32'h40);
            chk("pc40_hold", hold, 1'b1);
            chk("pc40_nop", instruction, 32'h0);
        end
        @(negedge clk);
        chk("pc40_hit_hold", hold, 1'b0);
        chk("pc40_hit_instr", instruction, mem_word(32'h40));
        chk("pc40_req_drop", imem_req, 1'b0);
`ifdef IFETCH_STALL_CNT_EN
        chk("pc40_stall_delta", stall_count - sc0, 32'd6);
`endif

        // sequential advance to 0x44
        pc = 32'h44; rsp_wait = 0;
        #1 chk("pc44_hold_rise", hold, 1'b1);
        @(negedge clk);
        chk("pc44_req", imem_req, 1'b1);
        chk("pc44_addr", imem_addr, 32'h44);
        @(negedge clk);
        chk("pc44_hit_hold", hold, 1'b0);
        chk("pc44_hit_instr", instruction, mem_word(32'h44));

        // bus error at 0x80, fault is sticky against stray acks
        pc = 32'h80; rsp_err = 1'b1;
        @(negedge clk);
        chk("err_req", imem_req, 1'b1);
        chk("err_fault_pre", fetch_fault, 1'b0);
        @(negedge clk);
        chk("err_fault", fetch_fault, 1'b1);
        chk("err_req_drop", imem_req, 1'b0);
        chk("err_hold", hold, 1'b1);
        rsp_spur = 1'b1; rsp_err = 1'b0; bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!fetch_fault || !hold || instruction != 32'h0 || imem_req) bad++;
        end
        chk("err_sticky_bad_cycles", bad, 0);
        reset = 1'b1;
        #1 chk("err_reset_clears", fetch_fault, 1'b0);

        // timeout after exactly 8 request cycles
        rsp_spur = 1'b0; rsp_mute = 1'b1; pc = 32'h100;
        @(negedge clk);
        reset = 1'b0;
        rq = 0; g = 0;
        @(negedge clk);
        while (imem_req && g < 50) begin
            rq++;
            g++;
            @(negedge clk);
        end
        chk("tmo_req_cycles", rq, 8);
        chk("tmo_fault", fetch_fault, 1'b1);
        chk("tmo_req_low", imem_req, 1'b0);

        // misaligned pc faults without a request
        reset = 1'b1; rsp_mute = 1'b0; pc = 32'h42;
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (imem_req) bad++;
        end
        chk("misalign_no_req", bad, 0);
        chk("misalign_fault", fetch_fault, 1'b1);
        chk("misalign_hold", hold, 1'b1);

        // reset in the middle of a pending fetch
        reset = 1'b1; rsp_mute = 1'b1; pc = 32'h200;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("midwait_req", imem_req, 1'b1);
        reset = 1'b1;
        #1;
        chk("midwait_req_async", imem_req, 1'b0);
        chk("midwait_addr_async", imem_addr, 32'h0);
        chk("midwait_hold", hold, 1'b1);
`ifdef IFETCH_STALL_CNT_EN
        chk("midwait_stall_async", stall_count, 32'h0);
`endif
        rsp_mute = 1'b0; rsp_spur = 1'b1;
        repeat (2) @(negedge clk);

        run_random(200);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mod_instr_fetch.md
# mod_instr_fetch

Instruction fetch stage placed directly upstream of `mod_mips_processor`. It consumes the processor's `rg_pc`, fetches the addressed word from a wait-stated instruction memory over a req/ack handshake, and presents it on `instruction`. While the word is not yet available it asserts `hold` to freeze the PC and feeds a NOP. Memory errors, timeouts and misaligned PCs drive it into a sticky fault state.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles `imem_req` may stay high without `imem_ack` before faulting; must be 1..65535.
- `NOP_WORD`, default 32'h0000_0000: word driven on `instruction` whenever `hold` is high (`sll $0,$0,0`).

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `pc`  in  32  connected to processor `rg_pc`.
- `instruction`  out  32  to processor `instruction`.
- `hold`  out  1  to processor `hold`; high = PC must not advance.
- `imem_req`  out  1  registered fetch request.
- `imem_addr`  out  32  registered fetch address; stable while `imem_req` is high.
- `imem_ack`  in  1  memory completion; `imem_rdata`/`imem_err` are valid in the same cycle.
- `imem_rdata`  in  32  fetched word.
- `imem_err`  in  1  bus error; meaningful only with `imem_ack`.
- `fetch_fault`  out  1  sticky fault indicator.

## Operation
- State: FSM {IDLE, WAIT, FAULT}, 1-entry buffer {`rg_valid`, `rg_tag[31:0]`, `rg_instr[31:0]`}, and a timeout counter of width $clog2(TIMEOUT_CYCLES+1).
- Hit = `state==IDLE && rg_valid && rg_tag==pc`.
- Outputs are combinational from the registers: `hold = !hit`; `instruction = hit ? rg_instr : NOP_WORD`.
- IDLE, miss with `pc[1:0]!=0`: go to FAULT. No request is issued.
- IDLE, miss with aligned pc: load `imem_addr<=pc`, `imem_req<=1`, clear the timeout counter, go to WAIT.
- IDLE, hit: stay in IDLE.
- WAIT, `imem_ack && !imem_err`: `rg_instr<=imem_rdata`, `rg_tag<=imem_addr`, `rg_valid<=1`, `imem_req<=0`, go to IDLE.
- WAIT, `imem_ack && imem_err`: `imem_req<=0`, `rg_valid<=0`, go to FAULT.
- WAIT, no ack: increment the timeout counter. When the counter reaches TIMEOUT_CYCLES, `imem_req<=0` and go to FAULT. Ack wins over timeout in the same cycle.
- FAULT: `fetch_fault=1`, `hold=1`, `instruction=NOP_WORD`. The block stays here until `reset`.
- `imem_ack` while `imem_req` is low is ignored.
- A `pc` change during WAIT (illegal, since hold is high) is tolerated. The fetched word installs under `imem_addr`'s tag, and the next IDLE cycle misses again.

## Timing
- Reset values: state=IDLE, `rg_valid=0`, `rg_tag=0`, `rg_instr=0`, `imem_req=0`, `imem_addr=0`, timeout counter=0, `fetch_fault=0`. Consequently `hold=1` and `instruction=NOP_WORD` during and after reset until the first fill.
- Reset asserted mid-WAIT drops `imem_req` immediately (asynchronous reset). Any late ack is ignored.
- Miss latency, miss detected in cycle N:
  - `imem_req` is high from cycle N+1.
  - With ack in cycle N+k (k≥1), `hold` falls and the word is presented in cycle N+k+1.
  - The processor advances the PC at the end of that cycle.
- Throughput with a zero-wait memory (ack in first req cycle): one instruction per 3 cycles.
- `imem_req` never deasserts without ack, except on timeout or reset.

## Configuration
- `IFETCH_STALL_CNT_EN`: when defined, adds output `stall_count[31:0]`.
  - Reset value 0.
  - Increments on every posedge where `hold==1` and `reset==0`, including FAULT cycles.
  - Saturates at 32'hFFFF_FFFF.
- When undefined, the port and counter do not exist; behaviour is otherwise identical.

## Test plan
- Reset then pc=0, memory acks on 1st req cycle with 32'h2002_0005:
  - `imem_req` rises 1 cycle after reset release with `imem_addr`=0.
  - The next cycle shows `hold`=0 and `instruction`=32'h2002_0005.
- pc=0x40, memory acks after 4 wait cycles:
  - `imem_req` stays high 5 cycles with `imem_addr`=0x40 stable.
  - `hold`=1 and `instruction`=0 throughout, then a hit.
- pc=0x40→0x44 after a hit: `hold` rises in the cycle pc changes, and a new req goes out for 0x44.
- Ack with `imem_err`=1 on pc=0x80: `fetch_fault`=1 the next cycle and stays 1 for 100 cycles. `reset` clears it.
- TIMEOUT_CYCLES=8, no ack: `imem_req` drops and `fetch_fault` rises after exactly 8 req-high cycles without ack. Misaligned pc=0x42 faults with `imem_req` never asserted.
- With `IFETCH_STALL_CNT_EN`: the 4-wait-state fetch adds 6 to `stall_count`. Reset mid-WAIT returns `stall_count`=0 and `imem_req`=0 asynchronously.
